firebird7_in_gate1_tessent_data_mux_sync: RTL and testbench
===========================================================

Name: firebird7_in_gate1_tessent_data_mux_sync

Overview:
- Multi-channel, parametrised IJTAG data override mux. It is the clocked successor of the single-channel combinational w3 data mux.
- Each channel passes functional data or a shadow-registered IJTAG override value to its output.
- Switchover between sources is a hold-and-switch sequence: the output freezes for a programmable number of cycles, so no partially updated data reaches the instrument.
- Also provides a capture snapshot of functional data for IJTAG readback. Sits between SIB-controlled TDRs and gated functional inputs.

Parameters:
WIDTH, 3, data bits per channel
NUM_CH, 1, number of independent channels
HOLD_CYCLES, 2, freeze cycles on each switchover; legal range 1..15 (elaboration error otherwise)

Ports:
ijtag_tck  input  1  single clock for all state
ijtag_reset  input  1  synchronous, active-high reset
ijtag_select  input  NUM_CH  per-channel request: 1 = IJTAG source, 0 = functional
ijtag_update_en  input  1  loads ijtag_data_in into all shadow registers
ijtag_capture_en  input  1  snapshots functional_data_in into capture register
ijtag_data_in  input  NUM_CH*WIDTH  override data; channel c = bits [c*WIDTH +: WIDTH]
functional_data_in  input  NUM_CH*WIDTH  functional data, same packing
data_out  output  NUM_CH*WIDTH  muxed data, same packing
capture_data_out  output  NUM_CH*WIDTH  captured functional data
switch_busy  output  NUM_CH  1 while channel in a hold state
active_sel  output  NUM_CH  1 while channel in IJTAG state

Behaviour:
- Per-channel FSM states: FUNC, HOLD_TO_IJ, IJTAG, HOLD_TO_FN. Counter cnt is 4 bits wide.
- Reset: FSM = FUNC, cnt = 0, hold_q = 0, shadow_q = 0, capture_q = 0. Consequently data_out = functional_data_in, and switch_busy, active_sel and capture_data_out are 0.
- data_out is a combinational select driven by registered state:
  - FUNC: functional_data_in, zero latency.
  - IJTAG: shadow_q.
  - Either hold state: hold_q.
- FUNC with ijtag_select=1 -> HOLD_TO_IJ. Same edge: hold_q <= functional_data_in, cnt <= HOLD_CYCLES-1.
- HOLD_TO_IJ:
  - ijtag_select=0 aborts to FUNC next cycle.
  - Otherwise, at cnt==0 -> IJTAG; else cnt decrements.
- IJTAG with ijtag_select=0 -> HOLD_TO_FN. Same edge: hold_q <= shadow_q, cnt <= HOLD_CYCLES-1.
- HOLD_TO_FN:
  - ijtag_select=1 aborts to IJTAG next cycle.
  - Otherwise, at cnt==0 -> FUNC; else cnt decrements.
- Hold duration: select edge to data_out showing the new source is exactly HOLD_CYCLES+1 clock edges.
- ijtag_update_en: shadow_q <= ijtag_data_in for all channels, in any state. In the IJTAG state data_out shows the new value one cycle later. An update during a hold state does not alter hold_q.
- ijtag_capture_en: capture_q <= functional_data_in, independent of FSM state.
- Simultaneous update and capture: both registers load.
- Channels are fully independent; no cross-channel arbitration.
- Reset mid-hold: immediate return to FUNC, shadow cleared. Reset has priority over every other input.

Optional Feature:
- Macro: FIREBIRD7_DATA_MUX_PARITY_EN.
- With the macro:
  - Extra ports ijtag_parity_in (input, NUM_CH) and parity_err (output, NUM_CH).
  - Even parity of each channel's ijtag_data_in slice is checked against ijtag_parity_in on ijtag_update_en.
  - A mismatch sets sticky parity_err[c]; only reset clears it.
  - While parity_err[c]=1, FUNC ignores ijtag_select, so the channel never enters the IJTAG path.
- Without the macro: ports, logic and flop absent; behaviour exactly as above.

Decomposition:
- Package firebird7_in_gate1_tessent_data_mux_pkg holds:
  - state enum type (FUNC, HOLD_TO_IJ, IJTAG, HOLD_TO_FN)
  - CNT_W = 4 constant
  - HOLD_CYCLES range-check constants
- Sub-module firebird7_in_gate1_tessent_data_mux_sync_ch holds one channel's FSM, counter, hold_q and shadow_q. The top generates NUM_CH instances and owns capture_q.

Test Plan:
- Reset, then functional_data_in=3'b101, select=0 -> data_out=3'b101 same cycle; busy=0, active_sel=0, capture_data_out=0.
- update_en with ijtag_data_in=3'b011, then select 0->1 with functional held at 3'b101 -> data_out=3'b101 for 2 cycles with busy=1, then 3'b011 with active_sel=1 on the 3rd edge.
- In IJTAG, functional toggles every cycle and select 1->0 -> data_out holds 3'b011 for HOLD_CYCLES, then tracks functional.
- Abort: select 0->1, then back to 0 after 1 cycle (HOLD_CYCLES=4) -> FUNC next cycle; active_sel never asserts.
- NUM_CH=2, WIDTH=8: channel 1 switched while channel 0 stays functional; same-cycle update_en+capture_en -> shadow and capture both load; channel 0 output undisturbed.
- Parity build: update with data 8'h01 and parity_in=0 -> parity_err=1; subsequent select=1 keeps channel in FUNC; reset clears parity_err.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared types and constants for the firebird7 IJTAG data override mux.
// Holds the per-channel state encoding, the hold counter width and the
// legal HOLD_CYCLES window.
package firebird7_in_gate1_tessent_data_mux_pkg;

  // Width of the per-channel hold counter.
  localparam int CNT_W = 4;

  // Legal HOLD_CYCLES window: at least one frozen cycle, at most what the counter can load.
  localparam int HOLD_CYCLES_MIN = 1;
  localparam int HOLD_CYCLES_MAX = (1 << CNT_W) - 1;

  // Per-channel switchover state.
  typedef enum logic [1:0] {
    FUNC       = 2'd0,
    HOLD_TO_IJ = 2'd1,
    IJTAG      = 2'd2,
    HOLD_TO_FN = 2'd3
  } mux_state_t;

  // True when a requested hold length fits the counter and is non-zero.
  function automatic bit hold_cycles_ok(input int hold_cycles);
    return (hold_cycles >= HOLD_CYCLES_MIN) && (hold_cycles <= HOLD_CYCLES_MAX);
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_sync_ch.sv
// One channel of the firebird7 IJTAG data override mux.
// Owns the switchover FSM, the hold counter, the frozen hold value and the
// shadow register that carries the IJTAG override value.
module firebird7_in_gate1_tessent_data_mux_sync_ch
  import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             select,
  input  logic             update_en,
  input  logic             block_select,
  input  logic [WIDTH-1:0] ijtag_data,
  input  logic [WIDTH-1:0] functional_data,
  output logic [WIDTH-1:0] data_out,
  output logic             switch_busy,
  output logic             active_sel
);

  // Counter load value: the hold state is left on the edge after cnt reaches
  // zero, giving HOLD_CYCLES frozen cycles.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  mux_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] hold_reg;
  logic [WIDTH-1:0] shadow_reg;

  // Shadow load plus the hold-and-switch sequencer; reset wins over everything.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state_reg  <= FUNC;
      cnt_reg    <= '0;
      hold_reg   <= '0;
      shadow_reg <= '0;
    end else begin
      if (update_en) begin
        shadow_reg <= ijtag_data;
      end
      case (state_reg)
        FUNC: begin
          if (select && !block_select) begin
            state_reg <= HOLD_TO_IJ;
            hold_reg  <= functional_data;
            cnt_reg   <= HOLD_LOAD;
          end
        end
        HOLD_TO_IJ: begin
          if (!select) begin
            state_reg <= FUNC;
          end else if (cnt_reg == '0) begin
            state_reg <= IJTAG;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        IJTAG: begin
          if (!select) begin
            state_reg <= HOLD_TO_FN;
            hold_reg  <= shadow_reg;
            cnt_reg   <= HOLD_LOAD;
          end
        end
        HOLD_TO_FN: begin
          if (select) begin
            state_reg <= IJTAG;
          end else if (cnt_reg == '0) begin
            state_reg <= FUNC;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= FUNC;
        end
      endcase
    end
  end

  // Output source select; functional path is zero-latency in FUNC.
  always_comb begin
    data_out = functional_data;
    case (state_reg)
      FUNC:       data_out = functional_data;
      IJTAG:      data_out = shadow_reg;
      HOLD_TO_IJ: data_out = hold_reg;
      HOLD_TO_FN: data_out = hold_reg;
      default:    data_out = functional_data;
    endcase
  end

  // Status flags decoded straight from the state register.
  always_comb begin
    switch_busy = (state_reg == HOLD_TO_IJ) || (state_reg == HOLD_TO_FN);
    active_sel  = (state_reg == IJTAG);
  end

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_sync.sv
// firebird7 multi-channel IJTAG data override mux (clocked).
// Generates NUM_CH independent channels and owns the functional capture
// register used for IJTAG readback.
// Optional build macro FIREBIRD7_DATA_MUX_PARITY_EN adds even-parity checking
// of override data with a sticky per-channel error that locks the channel
// onto its functional source.
module firebird7_in_gate1_tessent_data_mux_sync
  import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int NUM_CH      = 1,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                    ijtag_tck,
  input  logic                    ijtag_reset,
  input  logic [NUM_CH-1:0]       ijtag_select,
  input  logic                    ijtag_update_en,
  input  logic                    ijtag_capture_en,
  input  logic [NUM_CH*WIDTH-1:0] ijtag_data_in,
  input  logic [NUM_CH*WIDTH-1:0] functional_data_in,
`ifdef FIREBIRD7_DATA_MUX_PARITY_EN
  input  logic [NUM_CH-1:0]       ijtag_parity_in,
  output logic [NUM_CH-1:0]       parity_err,
`endif
  output logic [NUM_CH*WIDTH-1:0] data_out,
  output logic [NUM_CH*WIDTH-1:0] capture_data_out,
  output logic [NUM_CH-1:0]       switch_busy,
  output logic [NUM_CH-1:0]       active_sel
);

  // Reject hold lengths the 4-bit counter cannot represent.
  if (!hold_cycles_ok(HOLD_CYCLES)) begin : g_bad_hold
    $error("HOLD_CYCLES=%0d outside legal range %0d..%0d",
           HOLD_CYCLES, HOLD_CYCLES_MIN, HOLD_CYCLES_MAX);
  end

  logic [NUM_CH*WIDTH-1:0] capture_reg;
  logic [NUM_CH-1:0]       block_sel;

`ifdef FIREBIRD7_DATA_MUX_PARITY_EN
  logic [NUM_CH-1:0] parity_err_reg;

  // Sticky parity error: an update whose data parity disagrees with the
  // supplied even-parity bit flags that channel until reset.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      parity_err_reg <= '0;
    end else if (ijtag_update_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ((^ijtag_data_in[c*WIDTH +: WIDTH]) != ijtag_parity_in[c]) begin
          parity_err_reg[c] <= 1'b1;
        end
      end
    end
  end

  assign parity_err = parity_err_reg;
  assign block_sel  = parity_err_reg;
`else
  assign block_sel = '0;
`endif

  // Functional snapshot for readback, independent of any channel state.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      capture_reg <= '0;
    end else if (ijtag_capture_en) begin
      capture_reg <= functional_data_in;
    end
  end

  assign capture_data_out = capture_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    firebird7_in_gate1_tessent_data_mux_sync_ch #(
      .WIDTH       (WIDTH),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_ch (
      .ijtag_tck       (ijtag_tck),
      .ijtag_reset     (ijtag_reset),
      .select          (ijtag_select[gi]),
      .update_en       (ijtag_update_en),
      .block_select    (block_sel[gi]),
      .ijtag_data      (ijtag_data_in[gi*WIDTH +: WIDTH]),
      .functional_data (functional_data_in[gi*WIDTH +: WIDTH]),
      .data_out        (data_out[gi*WIDTH +: WIDTH]),
      .switch_busy     (switch_busy[gi]),
      .active_sel      (active_sel[gi])
    );
  end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_sync.sv
// Self-checking bench for firebird7_in_gate1_tessent_data_mux_sync.
// dut_a: WIDTH=3, NUM_CH=1, HOLD_CYCLES=2. dut_b: WIDTH=8, NUM_CH=2, HOLD_CYCLES=4.
// Parity checks are included when FIREBIRD7_DATA_MUX_PARITY_EN is defined.
module tb_firebird7_in_gate1_tessent_data_mux_sync;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut_a signals
  logic       a_sel, a_upd, a_cap;
  logic [2:0] a_ijd, a_fd, a_out, a_cap_out;
  logic       a_busy, a_act;

  // dut_b signals
  logic [1:0]  b_sel, b_busy, b_act;
  logic        b_upd, b_cap;
  logic [15:0] b_ijd, b_fd, b_out, b_cap_out;

`ifdef FIREBIRD7_DATA_MUX_PARITY_EN
  logic       a_par, a_perr;
  logic [1:0] b_par, b_perr, b_par_val;
  logic       b_par_force;
  assign a_par = ^a_ijd;
  assign b_par = b_par_force ? b_par_val : {^b_ijd[15:8], ^b_ijd[7:0]};
`endif

  firebird7_in_gate1_tessent_data_mux_sync #(
    .WIDTH(3), .NUM_CH(1), .HOLD_CYCLES(2)
  ) dut_a (
    .ijtag_tck          (clk),
    .ijtag_reset        (rst),
    .ijtag_select       (a_sel),
    .ijtag_update_en    (a_upd),
    .ijtag_capture_en   (a_cap),
    .ijtag_data_in      (a_ijd),
    .functional_data_in (a_fd),
`ifdef FIREBIRD7_DATA_MUX_PARITY_EN
    .ijtag_parity_in    (a_par),
    .parity_err         (a_perr),
`endif
    .data_out           (a_out),
    .capture_data_out   (a_cap_out),
    .switch_busy        (a_busy),
    .active_sel         (a_act)
  );

  firebird7_in_gate1_tessent_data_mux_sync #(
    .WIDTH(8), .NUM_CH(2), .HOLD_CYCLES(4)
  ) dut_b (
    .ijtag_tck          (clk),
    .ijtag_reset        (rst),
    .ijtag_select       (b_sel),
    .ijtag_update_en    (b_upd),
    .ijtag_capture_en   (b_cap),
    .ijtag_data_in      (b_ijd),
    .functional_data_in (b_fd),
`ifdef FIREBIRD7_DATA_MUX_PARITY_EN
    .ijtag_parity_in    (b_par),
    .parity_err         (b_perr),
`endif
    .data_out           (b_out),
    .capture_data_out   (b_cap_out),
    .switch_busy        (b_busy),
    .active_sel         (b_act)
  );

  // Scoreboard: expectations queued with the stimulus, popped against observations.
  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
      $display("[TB] check %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  // Advance one edge and step clear of it before touching anything.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_sel = 1'b0; a_upd = 1'b0; a_cap = 1'b0; a_ijd = '0; a_fd = '0;
    b_sel = '0;   b_upd = 1'b0; b_cap = 1'b0; b_ijd = '0; b_fd = '0;
`ifdef FIREBIRD7_DATA_MUX_PARITY_EN
    b_par_force = 1'b0;
    b_par_val   = '0;
`endif
    step();
    step();
    rst = 1'b0;

    // ---------------- dut_a: reset state, zero-latency functional path
    a_fd = 3'b101;
    sb_push("a_rst_out", 32'h5);
    sb_push("a_rst_busy", 32'h0);
    sb_push("a_rst_act", 32'h0);
    sb_push("a_rst_cap", 32'h0);
    #1;
    sb_check(a_out); sb_check(a_busy); sb_check(a_act); sb_check(a_cap_out);

    // Load shadow; FUNC output unaffected.
    a_ijd = 3'b011; a_upd = 1'b1;
    sb_push("a_upd_func_out", 32'h5);
    step();
    a_upd = 1'b0;
    sb_check(a_out);

    // Switch to IJTAG: frozen 2 cycles even though functional changes, new source on 3rd edge.
    a_sel = 1'b1;
    sb_push("a_toij_e1_out", 32'h5); sb_push("a_toij_e1_busy", 32'h1); sb_push("a_toij_e1_act", 32'h0);
    step();
    sb_check(a_out); sb_check(a_busy); sb_check(a_act);
    a_fd = 3'b110;
    sb_push("a_toij_e2_out", 32'h5); sb_push("a_toij_e2_busy", 32'h1); sb_push("a_toij_e2_act", 32'h0);
    step();
    sb_check(a_out); sb_check(a_busy); sb_check(a_act);
    sb_push("a_toij_e3_out", 32'h3); sb_push("a_toij_e3_busy", 32'h0); sb_push("a_toij_e3_act", 32'h1);
    step();
    sb_check(a_out); sb_check(a_busy); sb_check(a_act);

    // Update while in IJTAG shows one cycle later.
    a_ijd = 3'b111; a_upd = 1'b1;
    sb_push("a_ij_upd_before", 32'h3);
    #1;
    sb_check(a_out);
    sb_push("a_ij_upd_after", 32'h7);
    step();
    a_upd = 1'b0;
    sb_check(a_out);

    // Return to functional with functional toggling each cycle.
    a_sel = 1'b0; a_fd = 3'b010;
    sb_push("a_tofn_e1_out", 32'h7); sb_push("a_tofn_e1_busy", 32'h1);
    step();
    sb_check(a_out); sb_check(a_busy);
    a_fd = 3'b101;
    sb_push("a_tofn_e2_out", 32'h7); sb_push("a_tofn_e2_busy", 32'h1);
    step();
    sb_check(a_out); sb_check(a_busy);
    a_fd = 3'b010;
    sb_push("a_tofn_e3_out", 32'h2); sb_push("a_tofn_e3_busy", 32'h0); sb_push("a_tofn_e3_act", 32'h0);
    step();
    sb_check(a_out); sb_check(a_busy); sb_check(a_act);
    a_fd = 3'b101;
    sb_push("a_fn_track", 32'h5);
    #1;
    sb_check(a_out);

    // Capture snapshot.
    a_fd = 3'b100; a_cap = 1'b1;
    step();
    a_cap = 1'b0; a_fd = 3'b000;
    sb_push("a_cap_val", 32'h4); sb_push("a_cap_out_fn", 32'h0);
    #1;
    sb_check(a_cap_out); sb_check(a_out);

    // Update during a hold does not alter the frozen value.
    a_fd = 3'b001; a_sel = 1'b1;
    step();
    a_ijd = 3'b010; a_upd = 1'b1;
    sb_push("a_hold_upd_out", 32'h1); sb_push("a_hold_upd_busy", 32'h1);
    step();
    a_upd = 1'b0;
    sb_check(a_out); sb_check(a_busy);
    a_fd = 3'b110;
    sb_push("a_hold_upd_ij_out", 32'h2); sb_push("a_hold_upd_ij_act", 32'h1);
    step();
    sb_check(a_out); sb_check(a_act);

    // Reset mid-hold: back to FUNC, shadow and capture cleared.
    a_sel = 1'b0;
    sb_push("a_midhold_busy", 32'h1); sb_push("a_midhold_out", 32'h2);
    step();
    sb_check(a_busy); sb_check(a_out);
    rst = 1'b1;
    step();
    rst = 1'b0; a_fd = 3'b011;
    sb_push("a_rst_hold_busy", 32'h0); sb_push("a_rst_hold_act", 32'h0);
    sb_push("a_rst_hold_out", 32'h3); sb_push("a_rst_hold_cap", 32'h0);
    #1;
    sb_check(a_busy); sb_check(a_act); sb_check(a_out); sb_check(a_cap_out);
    a_sel = 1'b1;
    step(); step(); step();
    sb_push("a_rst_shadow_out", 32'h0); sb_push("a_rst_shadow_act", 32'h1);
    sb_check(a_out); sb_check(a_act);
    a_sel = 1'b0;

    // ---------------- dut_b: two channels, WIDTH=8, HOLD_CYCLES=4
    b_fd = 16'h3CA5;
    sb_push("b_rst_out", 32'h3CA5); sb_push("b_rst_busy", 32'h0); sb_push("b_rst_cap", 32'h0);
    #1;
    sb_check(b_out); sb_check(b_busy); sb_check(b_cap_out);

    // Same-cycle update and capture both load.
    b_ijd = 16'h5A77; b_fd = 16'h1234; b_upd = 1'b1; b_cap = 1'b1;
    step();
    b_upd = 1'b0; b_cap = 1'b0;
    sb_push("b_updcap_cap", 32'h1234); sb_push("b_updcap_out", 32'h1234);
    #1;
    sb_check(b_cap_out); sb_check(b_out);

    // Abort on channel 1 after one cycle; channel 0 keeps tracking.
    b_sel = 2'b10;
    step();
    b_fd = 16'hABCD;
    sb_push("b_abort_busy", 32'h2); sb_push("b_abort_act", 32'h0); sb_push("b_abort_out", 32'h12CD);
    #1;
    sb_check(b_busy); sb_check(b_act); sb_check(b_out);
    b_sel = 2'b00;
    sb_push("b_abort_fn_busy", 32'h0); sb_push("b_abort_fn_act", 32'h0); sb_push("b_abort_fn_out", 32'hABCD);
    step();
    sb_check(b_busy); sb_check(b_act); sb_check(b_out);

    // Full switch of channel 1: four frozen cycles, IJTAG on the fifth edge.
    b_sel = 2'b10;
    for (int i = 1; i <= 4; i++) begin
      sb_push($sformatf("b_hold_e%0d_out", i), {16'h0, 8'hAB, 8'(8'h40 + i - 1)});
      sb_push($sformatf("b_hold_e%0d_busy", i), 32'h2);
      step();
      b_fd = {8'h99, 8'(8'h40 + i - 1)};
      #1;
      sb_check(b_out); sb_check(b_busy);
    end
    b_fd = 16'h9966;
    sb_push("b_ij_out", 32'h5A66); sb_push("b_ij_act", 32'h2); sb_push("b_ij_busy", 32'h0);
    step();
    sb_check(b_out); sb_check(b_act); sb_check(b_busy);
    b_sel = 2'b00;

`ifdef FIREBIRD7_DATA_MUX_PARITY_EN
    // ---------------- parity: bad update locks channel 0 onto functional
    rst = 1'b1;
    step();
    rst = 1'b0;
    b_ijd = 16'h0001; b_par_force = 1'b1; b_par_val = 2'b00; b_upd = 1'b1;
    step();
    b_upd = 1'b0; b_par_force = 1'b0;
    sb_push("b_perr_set", 32'h1); sb_push("a_perr_clean", 32'h0);
    #1;
    sb_check(b_perr); sb_check(a_perr);
    b_sel = 2'b01; b_fd = 16'h0042;
    step(); step(); step(); step(); step(); step();
    sb_push("b_perr_busy", 32'h0); sb_push("b_perr_act", 32'h0); sb_push("b_perr_out", 32'h0042);
    sb_check(b_busy); sb_check(b_act); sb_check(b_out);
    b_sel = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_push("b_perr_clr", 32'h0);
    #1;
    sb_check(b_perr);
`endif

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
